// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmit path.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        RTS       = 3'd2,
        SHIFT     = 3'd3,
        WAIT_IDLE = 3'd4
    } ps2_state_e;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_RESET    = 8'hFF;

    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_RESEND   = 8'hFE;

    // Falls per frame: 8 data, parity, stop, ack.
    localparam logic [3:0] FRAME_BITS   = 4'd11;

    // PS/2 uses odd parity over the data byte.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizer, stability filter and fall detector for one raw PS/2 line.
// The filtered level only moves after FILTER_LEN consecutive samples that
// disagree with it, which rejects glitches on the slow open-drain lines.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic line_i,
    output logic level_o,
    output logic fall_o
);

    localparam int CW = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic [1:0]    sync_q;
    logic          filt_q;
    logic          filt_d;
    logic          prev_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Count consecutive disagreeing samples; flip the level on the last one.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync_q[1] != filt_q) begin
            if (cnt_q == CNT_LAST) begin
                filt_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Idle PS/2 lines are high, so everything resets to 1.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= 2'b11;
            filt_q <= 1'b1;
            prev_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], line_i};
            filt_q <= filt_d;
            prev_q <= filt_q;
            cnt_q  <= cnt_d;
        end
    end

    assign level_o = filt_q;
    assign fall_o  = prev_q & ~filt_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter. Runs on the system clock,
// oversampling the keyboard clock, and drives the open-drain lines through
// drive-low enables. busy lets the neighbouring receive path ignore the bus.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       ack_ok,
    output logic       timeout,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_drive_low,
    output logic       ps2_data_drive_low
);

    import ps2_pkg::*;

    localparam int TMAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] INH_LOAD = TW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TO_LOAD  = TW'(TIMEOUT_CYCLES - 1);

    logic clk_level;
    logic clk_fall;
    logic data_level;
    logic data_fall_unused;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk_i   (clk),
        .rst_i   (rst),
        .line_i  (ps2_clk_in),
        .level_o (clk_level),
        .fall_o  (clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
        .clk_i   (clk),
        .rst_i   (rst),
        .line_i  (ps2_data_in),
        .level_o (data_level),
        .fall_o  (data_fall_unused)
    );

    ps2_state_e    state_q;
    logic [7:0]    byte_q;
    logic          parity_q;
    logic [3:0]    bit_cnt_q;
    logic [3:0]    bit_cnt_d;
    logic [TW-1:0] timer_q;
    logic          ack_pend_q;
    logic          tx_ready_q;
    logic          busy_q;
    logic          done_q;
    logic          ack_ok_q;
    logic          timeout_q;
    logic          clk_dl_q;
    logic          data_dl_q;
    logic          timer_zero;
    logic          timeout_hit;

    assign bit_cnt_d   = bit_cnt_q + 4'd1;
    assign timer_zero  = (timer_q == '0);
    // Expiry is checked before any fall, so a coincident fall loses.
    assign timeout_hit = timer_zero &&
                         ((state_q == RTS) || (state_q == SHIFT) || (state_q == WAIT_IDLE));

    // Transfer sequencer: inhibit, request-to-send, clock out the frame,
    // read the ack, then wait for the bus to go idle before reporting.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            byte_q     <= '0;
            parity_q   <= 1'b0;
            bit_cnt_q  <= '0;
            timer_q    <= '0;
            ack_pend_q <= 1'b0;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ack_ok_q   <= 1'b0;
            timeout_q  <= 1'b0;
            clk_dl_q   <= 1'b0;
            data_dl_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (timeout_hit) begin
                clk_dl_q   <= 1'b0;
                data_dl_q  <= 1'b0;
                done_q     <= 1'b1;
                ack_ok_q   <= 1'b0;
                timeout_q  <= 1'b1;
                tx_ready_q <= 1'b1;
                busy_q     <= 1'b0;
                state_q    <= IDLE;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (tx_valid && tx_ready_q) begin
                            byte_q     <= tx_data;
                            parity_q   <= odd_parity(tx_data);
                            tx_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                            clk_dl_q   <= 1'b1;
                            timer_q    <= INH_LOAD;
                            state_q    <= INHIBIT;
                        end
                    end
                    INHIBIT: begin
                        if (timer_zero) begin
                            // Start bit goes down while clock is still held;
                            // clock is released on the first RTS cycle.
                            data_dl_q <= 1'b1;
                            bit_cnt_q <= '0;
                            timer_q   <= TO_LOAD;
                            state_q   <= RTS;
                        end else begin
                            timer_q <= timer_q - 1'b1;
                        end
                    end
                    RTS, SHIFT: begin
                        clk_dl_q <= 1'b0;
                        if (clk_fall) begin
                            bit_cnt_q <= bit_cnt_d;
                            timer_q   <= TO_LOAD;
                            state_q   <= SHIFT;
                            if (bit_cnt_d <= 4'd8) begin
                                data_dl_q <= ~byte_q[bit_cnt_q[2:0]];
                            end else if (bit_cnt_d == 4'd9) begin
                                data_dl_q <= ~parity_q;
                            end else if (bit_cnt_d == 4'd10) begin
                                data_dl_q <= 1'b0;
                            end else if (bit_cnt_d == FRAME_BITS) begin
                                ack_pend_q <= ~data_level;
                                state_q    <= WAIT_IDLE;
                            end
                        end else begin
                            timer_q <= timer_q - 1'b1;
                        end
                    end
                    WAIT_IDLE: begin
                        if (clk_level && data_level) begin
                            done_q     <= 1'b1;
                            ack_ok_q   <= ack_pend_q;
                            timeout_q  <= 1'b0;
                            tx_ready_q <= 1'b1;
                            busy_q     <= 1'b0;
                            state_q    <= IDLE;
                        end else if (clk_fall) begin
                            timer_q <= TO_LOAD;
                        end else begin
                            timer_q <= timer_q - 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign tx_ready           = tx_ready_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign ack_ok             = ack_ok_q;
    assign timeout            = timeout_q;
    assign ps2_clk_drive_low  = clk_dl_q;
    assign ps2_data_drive_low = data_dl_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural keyboard on the
// open-drain lines.
module tb_ps2_host_tx;

    import ps2_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, done, ack_ok, timeout;
    logic       ps2_clk_drive_low, ps2_data_drive_low;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk_line, ps2_data_line;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;

    assign ps2_clk_line  = ~(ps2_clk_drive_low | dev_clk_low);
    assign ps2_data_line = ~(ps2_data_drive_low | dev_data_low);

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES (100),
        .TIMEOUT_CYCLES (5000),
        .FILTER_LEN     (4)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .tx_data            (tx_data),
        .tx_valid           (tx_valid),
        .tx_ready           (tx_ready),
        .busy               (busy),
        .done               (done),
        .ack_ok             (ack_ok),
        .timeout            (timeout),
        .ps2_clk_in         (ps2_clk_line),
        .ps2_data_in        (ps2_data_line),
        .ps2_clk_drive_low  (ps2_clk_drive_low),
        .ps2_data_drive_low (ps2_data_drive_low)
    );

    always @(negedge clk) if (done) done_cnt++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation ran past 2 ms, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        chk("accept_busy", busy, 1'b1);
        chk("accept_not_ready", tx_ready, 1'b0);
    endtask

    // Keyboard model. mode 0: ack, 1: no ack, 2: reset the host during bit 4.
    // bits[0]=start, [8:1]=data LSB first, [9]=parity, [10]=stop.
    task automatic dev_xfer(input int mode, output logic [10:0] bits);
        int w;
        bits = '1;
        w = 0;
        while (!(ps2_data_line == 1'b0 && ps2_clk_line == 1'b1) && w < 2000) begin
            tick();
            w++;
        end
        chk("rts_seen", (w < 2000), 1'b1);
        bits[0] = ps2_data_line;
        wait_cyc(200);
        for (int k = 1; k <= 11; k++) begin
            dev_clk_low = 1'b1;
            wait_cyc(200);
            if (mode == 2 && k == 4) begin
                rst = 1'b1;
                tick();
                chk("rst_clk_dl", ps2_clk_drive_low, 1'b0);
                chk("rst_data_dl", ps2_data_drive_low, 1'b0);
                chk("rst_tx_ready", tx_ready, 1'b1);
                chk("rst_no_done", done, 1'b0);
                rst = 1'b0;
                dev_clk_low = 1'b0;
                return;
            end
            if (k <= 10) bits[k] = ps2_data_line;
            dev_clk_low = 1'b0;
            if (k == 10 && mode == 0) begin
                wait_cyc(100);
                dev_data_low = 1'b1;
                wait_cyc(100);
            end else if (k < 11) begin
                wait_cyc(200);
            end
        end
        if (mode == 0) begin
            wait_cyc(50);
            dev_data_low = 1'b0;
        end
    endtask

    task automatic check_frame(input logic [10:0] fr, input logic [7:0] exp_byte,
                               input logic exp_par);
        chk("start_bit", fr[0], 1'b0);
        chk("data_byte", fr[8:1], exp_byte);
        chk("parity_bit", fr[9], exp_par);
        chk("stop_bit", fr[10], 1'b1);
    endtask

    task automatic wait_done(input logic exp_ack, input logic exp_to);
        int c;
        c = 0;
        while (!done && c < 20000) begin
            tick();
            c++;
        end
        chk("done_seen", (c < 20000), 1'b1);
        chk("done_ack_ok", ack_ok, exp_ack);
        chk("done_timeout", timeout, exp_to);
        chk("done_tx_ready", tx_ready, 1'b1);
        chk("done_busy", busy, 1'b0);
    endtask

    initial begin
        logic [10:0] fr;
        int          cyc;
        int          prev_done;

        // Reset state
        wait_cyc(3);
        chk("rst_tx_ready", tx_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ack_ok", ack_ok, 1'b0);
        chk("rst_timeout", timeout, 1'b0);
        chk("rst_clk_dl", ps2_clk_drive_low, 1'b0);
        chk("rst_data_dl", ps2_data_drive_low, 1'b0);
        rst = 1'b0;
        wait_cyc(10);

        // 1: 0xED acknowledged; bits 1,0,1,1,0,1,1,1 parity 1
        send(CMD_SET_LEDS);
        tick();
        chk("inhibit_clk_dl", ps2_clk_drive_low, 1'b1);
        chk("inhibit_data_dl", ps2_data_drive_low, 1'b0);
        dev_xfer(0, fr);
        check_frame(fr, 8'hED, 1'b1);
        wait_done(1'b1, 1'b0);
        wait_cyc(20);

        // 2: back-to-back 0x00 (parity 1) and 0x01 (parity 0)
        send(8'h00);
        dev_xfer(0, fr);
        check_frame(fr, 8'h00, 1'b1);
        wait_done(1'b1, 1'b0);
        send(8'h01);
        dev_xfer(0, fr);
        check_frame(fr, 8'h01, 1'b0);
        wait_done(1'b1, 1'b0);
        wait_cyc(20);

        // 3: no ack -> NACK
        send(CMD_ENABLE);
        dev_xfer(1, fr);
        check_frame(fr, 8'hF4, 1'b0);
        wait_done(1'b0, 1'b0);
        wait_cyc(20);

        // 4: keyboard never clocks -> timeout ~5000 cycles after RTS
        send(CMD_RESET);
        cyc = 0;
        while (!(ps2_data_line == 1'b0 && ps2_clk_line == 1'b1) && cyc < 2000) begin
            tick();
            cyc++;
        end
        chk("to_rts_seen", (cyc < 2000), 1'b1);
        cyc = 0;
        while (!done && cyc < 6000) begin
            tick();
            cyc++;
        end
        chk("to_window", (cyc >= 4997 && cyc <= 5001), 1'b1);
        chk("to_clk_dl", ps2_clk_drive_low, 1'b0);
        chk("to_data_dl", ps2_data_drive_low, 1'b0);
        chk("to_timeout", timeout, 1'b1);
        chk("to_ack_ok", ack_ok, 1'b0);
        chk("to_tx_ready", tx_ready, 1'b1);
        wait_cyc(20);

        // 5: reset during bit 4 of 0xF4, then 0xFF completes
        prev_done = done_cnt;
        send(CMD_ENABLE);
        dev_xfer(2, fr);
        wait_cyc(100);
        chk("rst_no_done_pulse", done_cnt, prev_done);
        send(CMD_RESET);
        dev_xfer(0, fr);
        check_frame(fr, 8'hFF, 1'b1);
        wait_done(1'b1, 1'b0);
        wait_cyc(20);

        // 6: tx_valid with 0xAA while busy is ignored
        prev_done = done_cnt;
        send(CMD_SET_LEDS);
        wait_cyc(10);
        tx_data  = 8'hAA;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        chk("busy_still_busy", busy, 1'b1);
        dev_xfer(0, fr);
        check_frame(fr, 8'hED, 1'b1);
        wait_done(1'b1, 1'b0);
        wait_cyc(300);
        chk("single_done", done_cnt, prev_done + 1);
        chk("idle_after", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable) from the system side to the keyboard.
- Drives the open-drain PS/2 clock and data lines through drive-low enables.
- Runs entirely on the system clock and oversamples the keyboard clock; it never clocks logic from the PS/2 clock.
- Sits beside the keyboard receive path; `busy` tells that path to ignore line activity during a transmission.

Parameters:
- INHIBIT_CYCLES, 12000, system cycles clock is held low before request-to-send (120 us @ 100 MHz)
- TIMEOUT_CYCLES, 2000000, max system cycles allowed between PS/2 clock falling edges (20 ms @ 100 MHz)
- FILTER_LEN, 8, consecutive equal samples required to accept a level change on a PS/2 input

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- tx_data  in  8  command byte
- tx_valid  in  1  request to send tx_data
- tx_ready  out  1  high in IDLE only; byte accepted when tx_valid && tx_ready
- busy  out  1  high from acceptance through final return to IDLE
- done  out  1  one-cycle pulse at end of every transfer (success, NACK or timeout)
- ack_ok  out  1  valid with done: device acknowledged
- timeout  out  1  valid with done: transfer aborted on timeout
- ps2_clk_in  in  1  raw PS/2 clock line
- ps2_data_in  in  1  raw PS/2 data line
- ps2_clk_drive_low  out  1  1 = pull PS/2 clock low
- ps2_data_drive_low  out  1  1 = pull PS/2 data low

Behaviour:
- Reset values, one cycle after rst sampled high:
  - tx_ready=1; busy, done, ack_ok, timeout, both drive_low = 0.
  - FSM in IDLE, counters cleared.
  - Reset mid-transfer releases both lines in that same cycle, with no done pulse.
- Input conditioning: each PS/2 input goes through a 2-flop synchronizer, then a stable filter that changes its output only after FILTER_LEN equal samples. Filter output resets to 1.
  - fall = prev_filtered & ~filtered, one cycle wide.
- Acceptance: on tx_valid && tx_ready, latch tx_data and compute parity = ~^tx_data (odd). Next cycle tx_ready=0, busy=1. tx_valid while busy is ignored.
- IDLE -> INHIBIT on acceptance.
- INHIBIT: clk_drive_low=1, data_drive_low=0 for INHIBIT_CYCLES cycles.
- INHIBIT -> RTS: data_drive_low=1 (start bit 0), then clk_drive_low=0 the cycle after. Clear the bit counter and the timeout counter.
- RTS/SHIFT: on each fall, increment bit counter n (1..11) and act on it:
  - n=1..8: data_drive_low = ~tx_data[n-1] (LSB first).
  - n=9: data_drive_low = ~parity.
  - n=10: data_drive_low=0 (stop bit, line released).
  - n=11: sample filtered data. Low means ack_ok=1, high means NACK. Go to WAIT_IDLE.
- WAIT_IDLE: wait until filtered clock and data are both 1, then pulse done with the ack_ok result (timeout=0). Return to IDLE; tx_ready=1 the next cycle.
- Timeout: the counter runs in RTS, SHIFT and WAIT_IDLE and clears on every fall. On reaching TIMEOUT_CYCLES:
  - release both lines;
  - pulse done with timeout=1, ack_ok=0;
  - go to IDLE.
- ack_ok and timeout hold their values until the next done.
- Falls seen in IDLE or INHIBIT are ignored.
- A fall coinciding with timeout expiry: the timeout wins.

Decomposition:
- Package ps2_pkg:
  - state enum (IDLE, INHIBIT, RTS, SHIFT, WAIT_IDLE);
  - command constants CMD_SET_LEDS=8'hED, CMD_ENABLE=8'hF4, CMD_RESET=8'hFF;
  - response constants RSP_ACK=8'hFA, RSP_RESEND=8'hFE;
  - bit-count constant 11.
- Sub-module ps2_line_filter (synchronizer + stable filter + fall detect), instantiated twice. Also reusable by a synchronous rewrite of the receive path.

Test Plan:
Bench settings: INHIBIT_CYCLES=100, TIMEOUT_CYCLES=5000, FILTER_LEN=4. The device model clocks at a 400-cycle period after seeing data low with clock released.
1. Send 0xED; model ACKs. Data bits sampled on model rising edges must read start 0, then 1,0,1,1,0,1,1,1, parity 1, stop 1. Expect a done pulse with ack_ok=1, timeout=0, and tx_ready back to 1.
2. Send 0x00, then 0x01 back-to-back. Parity must be 1, then 0. Expect two done pulses, each with ack_ok=1.
3. Model omits ACK (data stays high on bit 11). Expect done with ack_ok=0, timeout=0.
4. Model never clocks. 5000 cycles after RTS, expect both drive_low=0 and done with timeout=1, ack_ok=0.
5. Assert rst during bit 4 of a 0xF4 send. Next cycle expect both drive_low=0, tx_ready=1, no done pulse. A following 0xFF send must complete with ack_ok=1.
6. Pulse tx_valid with 0xAA while busy. Expect it ignored: the transmitted byte and parity match the original 0xED, and only one done pulse occurs.
